heart_rate_ctrl: RTL and testbench

Measurement sequencer for the heart-rate datapath.
- Detects rising edges on `pulse` and counts them over a fixed measurement window.
- At each window close, scales the count to beats-per-minute, saturates it to four digits, and runs a serial binary-to-BCD conversion.
- Publishes `thousands`/`hundreds`/`tens`/`ones` with a one-cycle valid strobe.
- Sits between the raw pulse input and the 7-segment display driver.

---
 rtl/heart_rate_ctrl_if.sv | 23 ++
 rtl/heart_rate_ctrl.sv | 164 ++++++++++++++++
 tb/tb_heart_rate_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/heart_rate_ctrl_if.sv
// rtl/heart_rate_ctrl_if.sv - pulse input and BCD result bundle for heart_rate_ctrl
interface heart_rate_ctrl_if;
  logic       enable;
  logic       pulse;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       bpm_valid;
  logic       over_range;
  logic       busy;
  logic       overrun;

  modport master (
    output enable, pulse,
    input  thousands, hundreds, tens, ones, bpm_valid, over_range, busy, overrun
  );

  modport slave (
    input  enable, pulse,
    output thousands, hundreds, tens, ones, bpm_valid, over_range, busy, overrun
  );
endinterface

// File: rtl/heart_rate_ctrl.sv
// rtl/heart_rate_ctrl.sv - windowed pulse counter, BPM scaling and serial BCD conversion
// Optional macro PULSE_SYNC_EN adds a 2-flop synchronizer on pulse.
module heart_rate_ctrl #(
  parameter int WINDOW_CYCLES = 32,
  parameter int SCALE         = 4,
  parameter int CNT_W         = 8
) (
  input logic             clk,
  input logic             rst,
  heart_rate_ctrl_if.slave bus
);

  localparam int WIN_W   = $clog2(WINDOW_CYCLES);
  localparam int PROD_W  = CNT_W + $clog2(SCALE + 1);
  localparam int CMP_W   = (PROD_W > 14) ? PROD_W : 14;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WINDOW_CYCLES < 20) begin : g_bad_window
    $error("heart_rate_ctrl: WINDOW_CYCLES must be >= 20");
  end
  if (SCALE < 1) begin : g_bad_scale
    $error("heart_rate_ctrl: SCALE must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  logic pulse_s;
`ifdef PULSE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], bus.pulse};
  end
  assign pulse_s = sync_q[1];
`else
  assign pulse_s = bus.pulse;
`endif

  logic             pulse_q;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d, cnt_plus;
  logic [CNT_W-1:0] raw_q, raw_d;
  logic             rise, tick;

  assign rise     = pulse_s & ~pulse_q;
  assign tick     = bus.enable && (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));
  assign cnt_plus = (rise && (pulse_cnt_q != CNT_MAX)) ? pulse_cnt_q + 1'b1 : pulse_cnt_q;

  state_t      state_q, state_d;
  logic [3:0]  shift_cnt_q, shift_cnt_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj;
  logic        sat_q, sat_d;
  logic [15:0] digits_q, digits_d;
  logic        over_q, over_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic [CMP_W-1:0] prod;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign prod    = CMP_W'(raw_q) * CMP_W'(SCALE);
  assign bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  always_comb begin
    win_cnt_d   = win_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    raw_d       = raw_q;
    overrun_d   = 1'b0;
    if (!bus.enable) begin
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
    end else if (tick) begin
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
      // A tick that lands while a conversion is in flight drops its count.
      if (state_q == S_IDLE) raw_d = cnt_plus;
      else                   overrun_d = 1'b1;
    end else begin
      win_cnt_d   = win_cnt_q + 1'b1;
      pulse_cnt_d = cnt_plus;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    sat_d       = sat_q;
    digits_d    = digits_q;
    over_d      = over_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_LOAD;
      end
      S_LOAD: begin
        sat_d       = (prod > CMP_W'(9999));
        bin_d       = sat_d ? 14'd9999 : prod[13:0];
        bcd_d       = '0;
        shift_cnt_d = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d       = {bcd_adj[14:0], bin_q[13]};
        bin_d       = {bin_q[12:0], 1'b0};
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == 4'd13) state_d = S_DONE;
      end
      S_DONE: begin
        digits_d = bcd_q;
        over_d   = sat_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pulse_q     <= 1'b0;
      win_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      raw_q       <= '0;
      state_q     <= S_IDLE;
      shift_cnt_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      sat_q       <= 1'b0;
      digits_q    <= '0;
      over_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pulse_q     <= pulse_s;
      win_cnt_q   <= win_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      raw_q       <= raw_d;
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      sat_q       <= sat_d;
      digits_q    <= digits_d;
      over_q      <= over_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.thousands  = digits_q[15:12];
  assign bus.hundreds   = digits_q[11:8];
  assign bus.tens       = digits_q[7:4];
  assign bus.ones       = digits_q[3:0];
  assign bus.bpm_valid  = valid_q;
  assign bus.over_range = over_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_heart_rate_ctrl.sv
// tb/tb_heart_rate_ctrl.sv - directed bench for heart_rate_ctrl (SCALE=4 and SCALE=1000 side by side)
module tb_heart_rate_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, en, pl;
  always #5 clk = ~clk;

  heart_rate_ctrl_if if_a ();
  heart_rate_ctrl_if if_b ();
  assign if_a.enable = en;
  assign if_a.pulse  = pl;
  assign if_b.enable = en;
  assign if_b.pulse  = pl;

  heart_rate_ctrl #(.WINDOW_CYCLES(W), .SCALE(4),    .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  heart_rate_ctrl #(.WINDOW_CYCLES(W), .SCALE(1000), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int vcnt_a = 0;

  // reference state: window position/count and one pending result
  int pos, acc, due, raw_p;
  bit prevp, pend;
  logic [15:0] exp_dig_a, exp_dig_b;
  bit exp_ovr_a, exp_ovr_b, exp_valid, exp_busy, exp_overrun;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int disp(input int raw, input int s);
    return (raw * s > 9999) ? 9999 : raw * s;
  endfunction

  task automatic model_step();
    int rise, raw;
    bit tick_now, was_pend;
    edge_n++;
    if (!rst) begin
      pos = 0; acc = 0; prevp = 0; pend = 0;
      exp_dig_a = '0; exp_dig_b = '0; exp_ovr_a = 0; exp_ovr_b = 0;
      exp_valid = 0; exp_overrun = 0;
    end else begin
      rise = (pl && !prevp) ? 1 : 0;
      prevp = pl;
      exp_valid = 0;
      exp_overrun = 0;
      tick_now = en && (pos == W - 1);
      was_pend = pend;
      if (pend && edge_n == due) begin
        exp_dig_a = bcd4(disp(raw_p, 4));
        exp_dig_b = bcd4(disp(raw_p, 1000));
        exp_ovr_a = (raw_p * 4 > 9999);
        exp_ovr_b = (raw_p * 1000 > 9999);
        exp_valid = 1;
        pend = 0;
      end
      if (!en) begin
        pos = 0; acc = 0;
      end else if (tick_now) begin
        raw = (acc + rise > 255) ? 255 : acc + rise;
        acc = 0; pos = 0;
        if (was_pend) exp_overrun = 1;
        else begin pend = 1; due = edge_n + 16; raw_p = raw; end
      end else begin
        acc = (acc + rise > 255) ? 255 : acc + rise;
        pos++;
      end
    end
    exp_busy = pend;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
      chk("dig_a",  {if_a.thousands, if_a.hundreds, if_a.tens, if_a.ones}, exp_dig_a);
      chk("dig_b",  {if_b.thousands, if_b.hundreds, if_b.tens, if_b.ones}, exp_dig_b);
      chk("ovr_a",  if_a.over_range, exp_ovr_a);
      chk("ovr_b",  if_b.over_range, exp_ovr_b);
      chk("vld_a",  if_a.bpm_valid, exp_valid);
      chk("vld_b",  if_b.bpm_valid, exp_valid);
      chk("busy_a", if_a.busy, exp_busy);
      chk("busy_b", if_b.busy, exp_busy);
      chk("ovrn_a", if_a.overrun, exp_overrun);
      chk("ovrn_b", if_b.overrun, exp_overrun);
      if (if_a.bpm_valid === 1'b1) vcnt_a++;
    end
  end

  task automatic drive(input logic r, input logic e, input logic p);
    @(negedge clk);
    #1;
    rst = r; en = e; pl = p;
  endtask

  logic [31:0] masks [9];
  logic [15:0] lit_a [8];
  logic [15:0] lit_b [8];
  bit          lit_ob [8];

  initial begin
    rst = 1'b0; en = 1'b0; pl = 1'b0;
    masks  = '{32'h0002_2222, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8010_0400, 32'h0000_0020,
               32'h0000_0101, 32'h0005_5555, 32'h0000_0248, 32'h0000_000A};
    lit_a  = '{16'h0020, 16'h0004, 16'h0000, 16'h0012, 16'h0004, 16'h0008, 16'h0040, 16'h0012};
    lit_b  = '{16'h5000, 16'h1000, 16'h0000, 16'h3000, 16'h1000, 16'h2000, 16'h9999, 16'h3000};
    lit_ob = '{0, 0, 0, 0, 0, 0, 1, 0};

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, (i % 2) == 0);
    chk("rst_dig_a",  {if_a.thousands, if_a.hundreds, if_a.tens, if_a.ones}, 16'h0000);
    chk("rst_busy_a", if_a.busy, 1'b0);
    chk("rst_vld_a",  if_a.bpm_valid, 1'b0);
    chk("rst_ovr_b",  if_b.over_range, 1'b0);

    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < W; i++) drive(1'b1, 1'b1, masks[k][i]);
      if (k >= 1) begin
        chk("win_lit_a",  {if_a.thousands, if_a.hundreds, if_a.tens, if_a.ones}, lit_a[k-1]);
        chk("win_lit_b",  {if_b.thousands, if_b.hundreds, if_b.tens, if_b.ones}, lit_b[k-1]);
        chk("win_lit_ob", if_b.over_range, lit_ob[k-1]);
      end
    end

    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("mid_busy_a", if_a.busy, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    chk("abort_dig_a",  {if_a.thousands, if_a.hundreds, if_a.tens, if_a.ones}, 16'h0000);
    chk("abort_busy_a", if_a.busy, 1'b0);
    chk("abort_busy_b", if_b.busy, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, (i % 3) == 0);
    chk("idle_busy_a", if_a.busy, 1'b0);
    chk("idle_dig_b",  {if_b.thousands, if_b.hundreds, if_b.tens, if_b.ones}, 16'h0000);
    chk("valid_count", vcnt_a, 8);

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
